// File: rtl/b01_tx_pkg.sv
// rtl/b01_tx_pkg.sv - shared types and helpers for the b01 serial transmitter
package b01_tx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_DRAIN,
    ST_GAP
  } tx_state_e;

  // Registered delay of outp on the b01 side relative to line1/line2.
  localparam int OUTP_LATENCY = 1;

  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/b01_tx_shreg.sv
// rtl/b01_tx_shreg.sv - load/shift-right register, serial input enters at the MSB
module b01_tx_shreg #(
  parameter int WIDTH = 8,
  parameter int OUT_W = WIDTH
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_load,
  input  logic             i_shift,
  input  logic [WIDTH-1:0] i_d,
  input  logic             i_sin,
  output logic [OUT_W-1:0] o_q
);

  logic [WIDTH-1:0] r_q;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_q <= '0;
    end else if (i_load) begin
      r_q <= i_d;
    end else if (i_shift) begin
      r_q <= WIDTH'({i_sin, r_q} >> 1);
    end
  end

  // Only the low OUT_W bits are exposed; serialisers need just the LSB.
  assign o_q = r_q[OUT_W-1:0];

endmodule

// File: rtl/b01_serial_tx.sv
// rtl/b01_serial_tx.sv - drives b01 line1/line2 LSB-first and captures the returning outp word
module b01_serial_tx
  import b01_tx_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int GAP   = 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             line1,
  output logic             line2,
  input  logic             outp,
  input  logic             overflw,
  output logic             res_valid,
  output logic [WIDTH-1:0] res_data,
  output logic             res_ovf,
  output logic             busy
);

  localparam int CW       = cnt_w(WIDTH);
  localparam int GW       = cnt_w(GAP);
  localparam int GAP_LAST = (GAP > 0) ? GAP - 1 : 0;

  tx_state_e        r_state;
  logic [CW-1:0]    r_cnt;
  logic [GW-1:0]    r_gap_cnt;
  logic             r_ovf_acc;
  logic             r_res_valid;
  logic             r_res_ovf;
  logic [WIDTH-1:0] r_res_data;

  logic             w_sa;
  logic             w_sb;
  logic [WIDTH-2:0] w_res;
  logic             w_accept;
  logic             w_shift;
  logic             w_capture;

  assign w_accept  = in_valid && (r_state == ST_IDLE);
  assign w_shift   = (r_state == ST_SHIFT);
  // outp trails the lines, so the first SHIFT edge has nothing to capture yet
  assign w_capture = (w_shift && (r_cnt >= CW'(OUTP_LATENCY))) || (r_state == ST_DRAIN);

  b01_tx_shreg #(.WIDTH(WIDTH), .OUT_W(1)) u_sa (
    .i_clk   (clock),
    .i_rst   (reset),
    .i_load  (w_accept),
    .i_shift (w_shift),
    .i_d     (op_a),
    .i_sin   (1'b0),
    .o_q     (w_sa)
  );

  b01_tx_shreg #(.WIDTH(WIDTH), .OUT_W(1)) u_sb (
    .i_clk   (clock),
    .i_rst   (reset),
    .i_load  (w_accept),
    .i_shift (w_shift),
    .i_d     (op_b),
    .i_sin   (1'b0),
    .o_q     (w_sb)
  );

  // Holds the first WIDTH-1 bits; the last bit joins directly at the DRAIN exit.
  b01_tx_shreg #(.WIDTH(WIDTH-1), .OUT_W(WIDTH-1)) u_res (
    .i_clk   (clock),
    .i_rst   (reset),
    .i_load  (1'b0),
    .i_shift (w_capture),
    .i_d     ('0),
    .i_sin   (outp),
    .o_q     (w_res)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_gap_cnt   <= '0;
      r_ovf_acc   <= 1'b0;
      r_res_valid <= 1'b0;
      r_res_data  <= '0;
      r_res_ovf   <= 1'b0;
    end else begin
      r_res_valid <= 1'b0;
      if (w_capture) r_ovf_acc <= r_ovf_acc | overflw;
      case (r_state)
        ST_IDLE: begin
          if (in_valid) begin
            r_cnt     <= '0;
            r_ovf_acc <= 1'b0;
            r_state   <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == CW'(WIDTH - 1)) r_state <= ST_DRAIN;
        end
        ST_DRAIN: begin
          r_res_data  <= {outp, w_res};
          r_res_ovf   <= r_ovf_acc | overflw;
          r_res_valid <= 1'b1;
          if (GAP > 0) begin
            r_gap_cnt <= '0;
            r_state   <= ST_GAP;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_GAP: begin
          if (r_gap_cnt == GW'(GAP_LAST)) r_state <= ST_IDLE;
          else r_gap_cnt <= r_gap_cnt + 1'b1;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign line1     = w_shift & w_sa;
  assign line2     = w_shift & w_sb;
  assign in_ready  = (r_state == ST_IDLE);
  assign busy      = (r_state != ST_IDLE);
  assign res_valid = r_res_valid;
  assign res_data  = r_res_data;
  assign res_ovf   = r_res_ovf;

endmodule

// File: tb/tb_b01_serial_tx.sv
// tb/tb_b01_serial_tx.sv - self-checking bench for b01_serial_tx with a loopback b01 stand-in
module tb_b01_serial_tx;

  localparam int W = 8;
  localparam int G = 1;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       in_valid = 1'b0;
  logic [7:0] op_a = 8'h00;
  logic [7:0] op_b = 8'h00;
  logic       overflw = 1'b0;
  logic       lb8 = 1'b0;
  logic       in_ready, busy, line1, line2, res_valid, res_ovf;
  logic [7:0] res_data;

  logic       in_valid4 = 1'b0;
  logic [3:0] op_a4 = 4'h0;
  logic [3:0] op_b4 = 4'h0;
  logic       lb4 = 1'b0;
  logic       in_ready4, busy4, l1_4, l2_4, res_valid4, res_ovf4;
  logic [3:0] res_data4;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clock = ~clock;

  b01_serial_tx #(.WIDTH(W), .GAP(G)) dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .op_a(op_a), .op_b(op_b), .line1(line1), .line2(line2),
    .outp(lb8), .overflw(overflw), .res_valid(res_valid),
    .res_data(res_data), .res_ovf(res_ovf), .busy(busy)
  );

  b01_serial_tx #(.WIDTH(4), .GAP(0)) dut4 (
    .clock(clock), .reset(reset), .in_valid(in_valid4), .in_ready(in_ready4),
    .op_a(op_a4), .op_b(op_b4), .line1(l1_4), .line2(l2_4),
    .outp(lb4), .overflw(1'b0), .res_valid(res_valid4),
    .res_data(res_data4), .res_ovf(res_ovf4), .busy(busy4)
  );

  // Loopback stand-in for b01: outp is the registered XOR of the two lines.
  always @(posedge clock) begin
    lb8 <= line1 ^ line2;
    lb4 <= l1_4 ^ l2_4;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: tracks the accept edge of the current word by edge number.
  int         m_cyc = 0;
  bit         m_have = 1'b0;
  int         m_s = 0;
  logic [7:0] m_a = 8'h00;
  logic [7:0] m_b = 8'h00;
  logic       m_acc = 1'b0;
  logic [7:0] m_data = 8'h00;
  logic       m_ovf = 1'b0;

  always begin
    @(posedge clock);
    m_cyc++;
    if (reset) begin
      m_have = 1'b0;
      m_data = 8'h00;
      m_ovf  = 1'b0;
    end else begin
      if (m_have && m_cyc >= m_s + 2 && m_cyc <= m_s + W + 1) m_acc = m_acc | overflw;
      if (m_have && m_cyc == m_s + W + 1) begin
        m_data = m_a ^ m_b;
        m_ovf  = m_acc;
      end
      if (in_valid && (!m_have || m_cyc > m_s + W + 1 + G)) begin
        m_have = 1'b1;
        m_s    = m_cyc;
        m_a    = op_a;
        m_b    = op_b;
        m_acc  = 1'b0;
      end
    end
  end

  logic e_l1, e_l2, e_rdy, e_rv;

  always begin
    @(posedge clock);
    #3;
    if (reset) begin
      chk("rst_line1", line1, 0);
      chk("rst_line2", line2, 0);
      chk("rst_in_ready", in_ready, 1);
      chk("rst_busy", busy, 0);
      chk("rst_res_valid", res_valid, 0);
      chk("rst_res_data", res_data, 0);
      chk("rst_res_ovf", res_ovf, 0);
    end else begin
      e_l1  = 1'b0;
      e_l2  = 1'b0;
      if (m_have && m_cyc >= m_s && m_cyc < m_s + W) begin
        e_l1 = m_a[m_cyc - m_s];
        e_l2 = m_b[m_cyc - m_s];
      end
      e_rdy = !m_have || (m_cyc >= m_s + W + 1 + G);
      e_rv  = m_have && (m_cyc == m_s + W + 1);
      chk("line1", line1, e_l1);
      chk("line2", line2, e_l2);
      chk("in_ready", in_ready, e_rdy);
      chk("busy", busy, !e_rdy);
      chk("res_valid", res_valid, e_rv);
      chk("res_data", res_data, m_data);
      chk("res_ovf", res_ovf, m_ovf);
    end
  end

  task automatic run_word(input logic [7:0] a, input logic [7:0] b, input int ovf_at,
                          output logic [7:0] l1v, output logic [7:0] l2v,
                          output logic [7:0] dat, output logic ovf,
                          output int rv_at, output int low);
    int t;
    l1v = 8'h00; l2v = 8'h00; dat = 8'h00; ovf = 1'b0; rv_at = -1; low = 0;
    @(negedge clock);
    op_a = a; op_b = b; in_valid = 1'b1;
    t = 0;
    while (!in_ready && t < 50) begin
      @(negedge clock);
      t++;
    end
    chk("accept_wait", in_ready, 1);
    @(negedge clock);
    in_valid = 1'b0;
    for (int j = 0; j < W + G + 3; j++) begin
      if (j < W) begin
        l1v[j] = line1;
        l2v[j] = line2;
      end
      if (!in_ready) low++;
      if (res_valid) begin
        rv_at = j;
        dat   = res_data;
        ovf   = res_ovf;
      end
      overflw = (j == ovf_at);
      @(negedge clock);
    end
    overflw = 1'b0;
  endtask

  logic [7:0] l1v, l2v, dat, d0, d1;
  logic       ovf, rdy_prev, rdy4;
  logic [3:0] d4;
  int         rv_at, low, nres, at0, at1, acc2, nrv, rv4, low4, t;

  initial begin
    repeat (2) @(negedge clock);
    chk("init_in_ready", in_ready, 1);
    chk("init_res_data", res_data, 0);
    chk("init_line1", line1, 0);
    chk("init_in_ready4", in_ready4, 1);
    chk("init_res_valid4", res_valid4, 0);
    reset = 1'b0;
    repeat (3) @(negedge clock);
    chk("idle_line1", line1, 0);
    chk("idle_line2", line2, 0);

    run_word(8'hA5, 8'h3C, -1, l1v, l2v, dat, ovf, rv_at, low);
    chk("a5_line1_bits", l1v, 8'hA5);
    chk("a5_line2_bits", l2v, 8'h3C);
    chk("a5_res_data", dat, 8'h99);
    chk("a5_res_ovf", ovf, 0);
    chk("a5_rv_edge", rv_at, 9);
    chk("a5_ready_low", low, 10);

    run_word(8'hA5, 8'h3C, 4, l1v, l2v, dat, ovf, rv_at, low);
    chk("ovf_inside", ovf, 1);
    run_word(8'hA5, 8'h3C, 0, l1v, l2v, dat, ovf, rv_at, low);
    chk("ovf_before_window", ovf, 0);
    run_word(8'hA5, 8'h3C, 8, l1v, l2v, dat, ovf, rv_at, low);
    chk("ovf_last_capture", ovf, 1);
    run_word(8'hA5, 8'h3C, 9, l1v, l2v, dat, ovf, rv_at, low);
    chk("ovf_after_window", ovf, 0);

    // Back-to-back with in_valid held high; second pair presented while busy.
    @(negedge clock);
    op_a = 8'hFF; op_b = 8'h00; in_valid = 1'b1;
    t = 0;
    while (!in_ready && t < 50) begin
      @(negedge clock);
      t++;
    end
    chk("b2b_accept_wait", in_ready, 1);
    @(negedge clock);
    op_a = 8'h0F; op_b = 8'h0F;
    rdy_prev = in_ready; nres = 0; at0 = -1; at1 = -1; acc2 = -1; d0 = 8'h00; d1 = 8'h00;
    for (int j = 0; j < 30; j++) begin
      if (rdy_prev && in_valid) begin
        in_valid = 1'b0;
        acc2 = j;
      end
      if (res_valid) begin
        if (nres == 0) begin d0 = res_data; at0 = j; end
        else begin d1 = res_data; at1 = j; end
        nres++;
      end
      rdy_prev = in_ready;
      @(negedge clock);
    end
    in_valid = 1'b0;
    chk("b2b_n_results", nres, 2);
    chk("b2b_first", d0, 8'hFF);
    chk("b2b_second", d1, 8'h00);
    chk("b2b_second_accept", acc2, W + 2 + G);
    chk("b2b_pulse_spacing", at1 - at0, W + 2 + G);

    // Asynchronous reset at E4 of a word.
    @(negedge clock);
    op_a = 8'hA5; op_b = 8'h3C; in_valid = 1'b1;
    t = 0;
    while (!in_ready && t < 50) begin
      @(negedge clock);
      t++;
    end
    chk("rst_word_accept_wait", in_ready, 1);
    @(posedge clock);
    #1 in_valid = 1'b0;
    repeat (4) @(posedge clock);
    #1;
    chk("pre_rst_line2", line2, 1);
    reset = 1'b1;
    #1;
    chk("midrst_line1", line1, 0);
    chk("midrst_line2", line2, 0);
    chk("midrst_in_ready", in_ready, 1);
    chk("midrst_res_valid", res_valid, 0);
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
    nrv = 0;
    repeat (12) begin
      if (res_valid) nrv++;
      @(negedge clock);
    end
    chk("aborted_no_res_valid", nrv, 0);
    run_word(8'h5A, 8'hC3, -1, l1v, l2v, dat, ovf, rv_at, low);
    chk("post_rst_res_data", dat, 8'h99);
    chk("post_rst_rv_edge", rv_at, 9);

    // WIDTH=4, GAP=0 instance.
    @(negedge clock);
    op_a4 = 4'h9; op_b4 = 4'h6; in_valid4 = 1'b1;
    chk("w4_ready_before", in_ready4, 1);
    @(negedge clock);
    in_valid4 = 1'b0;
    rv4 = -1; low4 = 0; d4 = 4'h0; rdy4 = 1'b0;
    for (int j = 0; j < 10; j++) begin
      if (!in_ready4) low4++;
      if (res_valid4) begin
        rv4  = j;
        d4   = res_data4;
        rdy4 = in_ready4;
      end
      @(negedge clock);
    end
    chk("w4_res_data", d4, 4'hF);
    chk("w4_rv_edge", rv4, 5);
    chk("w4_ready_in_rv_cycle", rdy4, 1);
    chk("w4_ready_low", low4, 5);
    chk("w4_res_ovf", res_ovf4, 0);

    // Randomised traffic against the model, with occasional resets.
    for (int i = 0; i < 400; i++) begin
      @(negedge clock);
      if (reset) reset = 1'b0;
      else if ($urandom_range(0, 79) == 0) reset = 1'b1;
      in_valid = ($urandom_range(0, 3) != 0);
      op_a     = 8'($urandom);
      op_b     = 8'($urandom);
      overflw  = ($urandom_range(0, 5) == 0);
    end
    @(negedge clock);
    reset = 1'b0; in_valid = 1'b0; overflw = 1'b0;
    repeat (W + G + 6) @(negedge clock);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
